// File: rtl/levenshtein_vector_loader.sv
// Loads the search word over a Wishbone slave, then streams the 128-entry
// pattern-match bit-vector table into shared memory through a write-only master.
module levenshtein_vector_loader #(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH  = 24,
  parameter int BITVECTOR_WIDTH   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  output logic [7:0]                   wbs_dat_o,
  output logic [BITVECTOR_WIDTH-1:0]   mask_o,
  output logic [BITVECTOR_WIDTH-1:0]   initial_vp_o,
  output logic                         done_o
);
  localparam int BW = BITVECTOR_WIDTH;
  localparam logic [4:0] BW_L = 5'(BITVECTOR_WIDTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic [6:0]           idx;
  logic [3:0]           len;
  logic                 busy, error, done_flag;
  logic [BW-1:0][6:0]   chars;
  logic [BW-1:0]        entry;
  logic                 fin, fail, adv;

  logic [3:0] adr;
  logic       slv_req, slv_wr, start_wr, len_ok, start_go, char_wr;
  logic       unused;

  assign adr      = wbs_adr_i[3:0];
  assign slv_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign slv_wr   = slv_req & wbs_we_i;
  assign start_wr = slv_wr & (adr == 4'h0) & wbs_dat_i[7] & ~busy;
  assign len_ok   = (wbs_dat_i[3:0] != 4'h0) && ({1'b0, wbs_dat_i[3:0]} <= BW_L);
  assign start_go = start_wr & len_ok;
  assign char_wr  = slv_wr & adr[3] & ({2'b0, adr[2:0]} < BW_L) & ~busy;
  assign unused   = ^{wbs_adr_i[SLAVE_ADDR_WIDTH-1:4], wbs_dat_i[6:4]};

  // Per-lane match: slots at or beyond len never contribute.
  for (genvar i = 0; i < BW; i++) begin : g_lane
    assign entry[i] = (4'(i) < len) && (chars[i] == idx);
  end

  assign wbm_cyc_o = (state == WAIT);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = 1'b1;
  assign wbm_adr_o = MASTER_ADDR_WIDTH'(idx);
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

  always_comb begin
    wbm_dat_o = '0;
    wbm_dat_o[BW-1:0] = entry;
  end

  always_comb begin
    state_nxt = state;
    fin  = 1'b0;
    fail = 1'b0;
    adv  = 1'b0;
    case (state)
      IDLE: if (start_go) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: begin
        // ack takes priority over a simultaneous err/rty
        if (wbm_ack_i) begin
          if (idx == 7'h7f) begin
            state_nxt = IDLE;
            fin = 1'b1;
          end else begin
            state_nxt = REQ;
            adv = 1'b1;
          end
        end else if (wbm_err_i | wbm_rty_i) begin
          state_nxt = IDLE;
          fail = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx          <= '0;
      len          <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
      done_flag    <= 1'b0;
      done_o       <= 1'b0;
      wbs_ack_o    <= 1'b0;
      mask_o       <= '0;
      initial_vp_o <= '0;
      chars        <= '0;
    end else begin
      wbs_ack_o <= slv_req;
      done_o    <= fin;
      if (start_wr) begin
        len       <= wbs_dat_i[3:0];
        error     <= ~len_ok;
        done_flag <= 1'b0;
        if (len_ok) begin
          busy <= 1'b1;
          idx  <= '0;
          for (int i = 0; i < BW; i++) begin
            initial_vp_o[i] <= (4'(i) < wbs_dat_i[3:0]);
            mask_o[i]       <= (5'(i) + 5'd1 == {1'b0, wbs_dat_i[3:0]});
          end
        end
      end
      for (int i = 0; i < BW; i++)
        if (char_wr && adr[2:0] == 3'(i)) chars[i] <= wbs_dat_i[6:0];
      if (adv) idx <= idx + 7'd1;
      if (fin) begin
        busy      <= 1'b0;
        done_flag <= 1'b1;
      end
      if (fail) begin
        busy  <= 1'b0;
        error <= 1'b1;
      end
    end
  end

  always_comb begin
    wbs_dat_o = '0;
    case (adr)
      4'h0: wbs_dat_o = {busy, error, done_flag, 1'b0, len};
      4'h1: wbs_dat_o[BW-1:0] = mask_o;
      4'h2: wbs_dat_o[BW-1:0] = initial_vp_o;
      default: begin
        for (int i = 0; i < BW; i++)
          if (adr[3] && adr[2:0] == 3'(i)) wbs_dat_o = {1'b0, chars[i]};
      end
    endcase
  end
endmodule

// File: tb/tb_levenshtein_vector_loader.sv
// Bench for the pattern-match table loader: table vectors, corner sequences
// and randomized words checked against a table model.
module tb_levenshtein_vector_loader;
  logic clk = 0, rst_ni = 0;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [23:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic ack = 0, err = 0, rty = 0;
  logic s_cyc = 0, s_stb = 0, s_we = 0;
  logic [23:0] s_adr = 0;
  logic [7:0] s_dat = 0;
  logic wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [7:0] wbs_dat_o, mask_o, initial_vp_o;
  logic done_o;

  levenshtein_vector_loader dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
    .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
    .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_adr_i(s_adr),
    .wbs_dat_i(s_dat), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o),
    .mask_o(mask_o), .initial_vp_o(initial_vp_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Memory-side slave model
  logic [7:0]  mem [128];
  logic        clr = 0;
  int          lat = 0, emode = 0;
  logic [23:0] err_adr = 24'hFFFFFF;
  int wcount = 0, done_cnt = 0, cyc_cnt = 0, proto_err = 0, wcnt = 0;
  logic [23:0] prev_adr = 0;
  logic [7:0]  prev_dat = 0;
  logic        prev_cyc = 0;

  always @(posedge clk) begin
    ack <= 0; err <= 0; rty <= 0;
    prev_cyc <= wbm_cyc_o; prev_adr <= wbm_adr_o; prev_dat <= wbm_dat_o;
    if (clr) begin
      wcount <= 0; done_cnt <= 0; cyc_cnt <= 0; proto_err <= 0; wcnt <= 0;
      for (int i = 0; i < 128; i++) mem[i] <= 8'hEE;
    end else begin
      if (done_o) done_cnt <= done_cnt + 1;
      if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
      if (wbm_cyc_o && prev_cyc && (wbm_adr_o != prev_adr || wbm_dat_o != prev_dat))
        proto_err <= proto_err + 1;
      if (wbm_cyc_o && !ack && !err && !rty) begin
        if (wcnt >= lat) begin
          wcnt <= 0;
          if (wbm_adr_o == err_adr && emode != 2) begin
            if (emode == 1) rty <= 1; else err <= 1;
          end else begin
            ack <= 1;
            if (wbm_adr_o == err_adr) err <= 1;
            mem[wbm_adr_o[6:0]] <= wbm_dat_o;
            wcount <= wcount + 1;
            if (wbm_adr_o != 24'(wcount) || !wbm_we_o || !wbm_stb_o)
              proto_err <= proto_err + 1;
          end
        end else wcnt <= wcnt + 1;
      end else if (!wbm_cyc_o) wcnt <= 0;
    end
  end

  function automatic int model_entry(logic [63:0] ch, int len, int c);
    int v = 0;
    for (int i = 0; i < len; i++)
      if (int'(ch[8*i +: 8] & 8'h7f) == c) v += (1 << i);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    bit ok = 0;
    q = 0;
    @(negedge clk);
    s_cyc = 1; s_stb = 1; s_we = we; s_adr = {20'h0, a}; s_dat = d;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin ok = 1; q = wbs_dat_o; break; end
    end
    s_cyc = 0; s_stb = 0; s_we = 0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL slave_ack_timeout: adr 0x%0h got no ack, expected ack", a);
    end
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic rd_chk(string nm, input logic [3:0] a, input int exp);
    logic [7:0] q;
    wb_xfer(1'b0, a, 8'h0, q);
    chk(nm, int'(q), exp);
  endtask

  task automatic clear_model();
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
  endtask

  task automatic start_run(input logic [63:0] ch, input int len);
    clear_model();
    for (int i = 0; i < 8; i++) wb_write(4'(8 + i), ch[8*i +: 8]);
    wb_write(4'h0, 8'h80 | 8'(len));
  endtask

  task automatic finish_run(string nm, input logic [63:0] ch, input int len,
                            input int estat, input bit chk_time);
    int cyc = 0, mism = 0;
    bit seen = 0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1; cyc++;
      if (done_o) begin seen = 1; break; end
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    if (chk_time) chk({nm, "_latency"}, cyc, 384);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_writes"}, wcount, 128);
    chk({nm, "_protocol"}, proto_err, 0);
    chk({nm, "_mask_o"}, int'(mask_o), 1 << (len - 1));
    chk({nm, "_ivp_o"}, int'(initial_vp_o), (1 << len) - 1);
    for (int c = 0; c < 128; c++)
      if (int'(mem[c]) != model_entry(ch, len, c)) mism++;
    chk({nm, "_table_mismatches"}, mism, 0);
    rd_chk({nm, "_status"}, 4'h0, estat);
    rd_chk({nm, "_mask_reg"}, 4'h1, 1 << (len - 1));
    rd_chk({nm, "_ivp_reg"}, 4'h2, (1 << len) - 1);
  endtask

  typedef struct {
    logic [63:0] chars;
    int len, status, probe_c, probe_v;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int snap;
    logic [63:0] ch;
    vecs[0] = '{64'h0000_0000_0000_6261, 2, 8'h22, 8'h61, 8'h01};
    vecs[1] = '{64'h0000_0000_0061_6161, 3, 8'h23, 8'h61, 8'h07};
    vecs[2] = '{64'h6867_6665_6463_6261, 8, 8'h28, 8'h68, 8'h80};
    vecs[3] = '{64'h0000_0000_6100_6362, 2, 8'h22, 8'h61, 8'h00};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", int'(wbm_cyc_o), 0);
    chk("rst_adr", int'(wbm_adr_o), 0);
    chk("rst_dat", int'(wbm_dat_o), 0);
    chk("rst_mask", int'(mask_o), 0);
    chk("rst_ivp", int'(initial_vp_o), 0);
    chk("rst_ack", int'(wbs_ack_o), 0);
    @(negedge clk); rst_ni = 1;
    rd_chk("rst_status", 4'h0, 0);
    rd_chk("rst_char0", 4'h8, 0);

    wb_write(4'hD, 8'hE1);
    rd_chk("char_bit7", 4'hD, 8'h61);
    rd_chk("unmapped", 4'h3, 0);

    for (int v = 0; v < 4; v++) begin
      lat = 0;
      start_run(vecs[v].chars, vecs[v].len);
      finish_run($sformatf("vec%0d", v), vecs[v].chars, vecs[v].len, vecs[v].status, 1'b1);
      chk($sformatf("vec%0d_probe", v), int'(mem[vecs[v].probe_c]), vecs[v].probe_v);
    end

    // Illegal lengths: error set, no master traffic
    clear_model();
    wb_write(4'h0, 8'h80);
    repeat (20) @(posedge clk);
    #1;
    chk("len0_cyc_count", cyc_cnt, 0);
    rd_chk("len0_status", 4'h0, 8'h40);
    wb_write(4'h0, 8'h89);
    repeat (20) @(posedge clk);
    #1;
    chk("len9_cyc_count", cyc_cnt, 0);
    rd_chk("len9_status", 4'h0, 8'h49);

    // err / rty abort at index 0x10; mode 2 has ack win over err
    for (int m = 0; m < 3; m++) begin
      bit seen = 0;
      emode = m; err_adr = 24'h10; lat = 0;
      start_run(vecs[0].chars, 2);
      if (m == 2) begin
        finish_run("ack_beats_err", vecs[0].chars, 2, 8'h22, 1'b0);
      end else begin
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk); #1;
          if (err || rty) begin seen = 1; break; end
        end
        chk($sformatf("abort%0d_seen", m), int'(seen), 1);
        @(posedge clk); #1;
        chk($sformatf("abort%0d_cyc_drop", m), int'(wbm_cyc_o), 0);
        snap = cyc_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk($sformatf("abort%0d_no_more_cyc", m), cyc_cnt - snap, 0);
        chk($sformatf("abort%0d_writes", m), wcount, 16);
        chk($sformatf("abort%0d_done", m), done_cnt, 0);
        rd_chk($sformatf("abort%0d_status", m), 4'h0, 8'h42);
      end
      err_adr = 24'hFFFFFF; emode = 0;
      if (m == 0) begin
        start_run(vecs[1].chars, 3);
        finish_run("after_err", vecs[1].chars, 3, 8'h23, 1'b1);
      end
    end

    // Reset in the middle of a run
    start_run(vecs[0].chars, 2);
    snap = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == 24'h20) begin snap = 1; break; end
    end
    chk("midrst_reached", snap, 1);
    rst_ni = 0;
    #1;
    chk("midrst_cyc", int'(wbm_cyc_o), 0);
    chk("midrst_mask", int'(mask_o), 0);
    chk("midrst_adr", int'(wbm_adr_o), 0);
    @(negedge clk); rst_ni = 1;
    chk("midrst_writes", wcount, 32);
    rd_chk("midrst_status", 4'h0, 0);
    rd_chk("midrst_char0", 4'h8, 0);
    rd_chk("midrst_mask_reg", 4'h1, 0);

    // Char and start writes while busy are acked but ignored
    start_run(vecs[0].chars, 2);
    wb_write(4'h8, 8'h7A);
    wb_write(4'h0, 8'h83);
    finish_run("busy_wr", vecs[0].chars, 2, 8'h22, 1'b0);
    rd_chk("busy_wr_char0", 4'h8, 8'h61);

    // Randomized words over a small alphabet, random memory latency
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        ch[8*i +: 8] = {1'($urandom_range(0, 1)), 7'(7'h61 + $urandom_range(0, 3))};
      lat = $urandom_range(0, 2);
      start_run(ch, len);
      finish_run($sformatf("rnd%0d", r), ch, len, 8'h20 | len, lat == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/levenshtein_vector_loader.md
# levenshtein_vector_loader

Upstream stage of the Levenshtein search engine. It takes the search word from the host over a Wishbone slave. It then writes the 128-entry pattern-match bit-vector table (one byte per 7-bit character code, at master addresses 0x00–0x7F) into the shared memory. The Levenshtein controller later reads that table at address `pm`. The block also computes the `mask` and `initial_vp` values the controller needs and exposes them as ports and readable registers.

## Interface
- `MASTER_ADDR_WIDTH`, 24, Wishbone master address width; table entry c is written at address c, zero-extended.
- `SLAVE_ADDR_WIDTH`, 24, Wishbone slave address width; only bits [3:0] are decoded.
- `BITVECTOR_WIDTH`, 8, maximum word length and bit-vector width; legal range 1..8.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `wbm_cyc_o` out 1, `wbm_stb_o` out 1: master cycle and strobe; always equal.
- `wbm_adr_o` out MASTER_ADDR_WIDTH: table index.
- `wbm_we_o` out 1: constant 1 (write-only master).
- `wbm_dat_o` out 8: bit-vector for the current index, zero-extended.
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i` in 1: master termination inputs.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1; `wbs_adr_i` in SLAVE_ADDR_WIDTH; `wbs_dat_i` in 8: slave request.
- `wbs_ack_o` out 1; `wbs_err_o`, `wbs_rty_o` out 1 (tied 0); `wbs_dat_o` out 8: slave response.
- `mask_o` out BITVECTOR_WIDTH: `1 << (len-1)`.
- `initial_vp_o` out BITVECTOR_WIDTH: `(1 << len) - 1`.
- `done_o` out 1: one-cycle pulse when the table is complete.

## Operation
- Slave register map (`wbs_adr_i[3:0]`):
  - 0x0 control/status. Write: bit7 = start, bits[3:0] = len. Read: {busy, error, done_flag, 1'b0, len[3:0]}.
  - 0x1 `mask`, read-only.
  - 0x2 `initial_vp`, read-only.
  - 0x8+i: word character i, for i < BITVECTOR_WIDTH; read/write, 7 bits stored, bit7 reads 0.
  - All other addresses read 0x00 and ignore writes.
- Slave handshake:
  - `wbs_ack_o` rises on the edge after a request is seen while ack is low.
  - It drops the following edge, so an ack lasts exactly one cycle per request.
  - `wbs_dat_o` is combinational from the address.
- While busy, writes to 0x0 and 0x8+ are acked but ignored.
- Start write while idle:
  - latches len and clears error and done_flag.
  - len = 0 or len > BITVECTOR_WIDTH: error=1, busy stays 0, no master traffic.
  - Otherwise: busy=1, index=0, and mask/initial_vp update on the same edge.
- Table entry for index c: bit i = (i < len) && (char[i] == c[6:0]). Characters at slots ≥ len never contribute.
- Master FSM states and transitions:
  - IDLE → REQ on start.
  - REQ: cyc=0; next edge sets cyc=1 and goes to WAIT.
  - WAIT, on ack: cyc=0. If index=127, go to IDLE with busy=0, done_flag=1 and a one-cycle `done_o` pulse. Otherwise increment index and go to REQ.
  - WAIT, on err or rty: cyc=0, busy=0, error=1, go to IDLE; no retry.
  - If ack and err arrive together, ack wins.
- Address and data are held stable while cyc=1.
- Index is 7 bits and never wraps past 127 within a run.

## Timing
- Reset values: cyc/stb 0, `wbm_adr_o` 0, `wbm_dat_o` equal to the entry for index 0 with len 0 (0x00), `wbs_ack_o` 0, `done_o` 0, `mask_o` 0, `initial_vp_o` 0, all chars 0, len 0, busy/error/done_flag 0.
- Reset mid-run: cyc drops asynchronously and the run is abandoned; the table is left partially written.
- Start acked at edge N: busy=1 at N; cyc rises at N+1.
- Each entry costs 1 REQ cycle + 1 cycle + ack latency. With a slave acking one cycle after stb, an entry takes 3 cycles and the full table 384 cycles from start ack to `done_o`.
- `done_o` is asserted on the edge after the final ack, for one cycle.

## Test plan
- Chars "ab" (0x61,0x62), len 2, start → exactly 128 writes at 0x00..0x7F; entry 0x61=0x01, 0x62=0x02, all others 0x00; mask 0x02, initial_vp 0x03; `done_o` pulses once; status reads 0x22.
- Chars "aaa", len 3 → entry 0x61=0x07; mask 0x04, initial_vp 0x07. Then len 8 with "abcdefgh" → mask 0x80, initial_vp 0xFF, entry 0x68=0x80.
- Slot 3 = 'a', chars "bc", len 2 → entry 0x61=0x00 (stale slot ignored).
- len 0 start → status reads 0x40, no cyc ever asserted.
- err on the write to index 0x10 → cyc low the next cycle, no further writes, status error=1, busy=0; a subsequent valid start clears error and completes.
- `rst_ni` low mid-run (index 0x20) → cyc low immediately, all registers cleared; a char write during busy is acked with no effect on stored chars.
